// File: rtl/systolic_feeder.sv
// Drive-side sequencer for the systolic array: loads a weight tile on the north edge,
// then issues the switch token and diagonally skewed input vectors on the west edge.
module systolic_feeder #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_IN        = 8,
    localparam int IW = $clog2(SYSTOLIC_ARRAY_WIDTH),
    localparam int CW = $clog2(SYSTOLIC_ARRAY_WIDTH + 1)
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                cmd_valid_in,
    output logic                                                cmd_ready_out,
    input  logic [CW-1:0]                                       cmd_k_in,
    input  logic [CW-1:0]                                       cmd_cols_in,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0][DATA_WIDTH_IN-1:0] w_data_in,
    input  logic                                                w_valid_in,
    output logic                                                w_ready_out,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0][DATA_WIDTH_IN-1:0] x_data_in,
    input  logic                                                x_valid_in,
    output logic                                                x_ready_out,
    input  logic                                                x_last_in,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0][DATA_WIDTH_IN-1:0] sys_weight_out,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0][IW-1:0]            sys_index_out,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0]                    sys_accept_w_out,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0][DATA_WIDTH_IN-1:0] sys_data_out,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0]                    sys_valid_out,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0]                    sys_switch_out,
    output logic [CW-1:0]                                       ub_rd_col_size_out,
    output logic                                                ub_rd_col_size_valid_out,
    output logic                                                done_out
);

    localparam int W  = SYSTOLIC_ARRAY_WIDTH;
    localparam int DW = DATA_WIDTH_IN;
    localparam logic [CW-1:0] W_C  = CW'(W);
    localparam logic [IW-1:0] LAST = IW'(W - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, SETTLE, SWITCH, STREAM, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [IW-1:0]        cnt;
    logic [CW-1:0]        k_q, cols_q;
    logic                 cmd_fire, w_take, w_beat, cnt_inc, done_nxt;
    logic                 s0_vld, s0_sw;
    logic [W-1:0][DW-1:0] s0_data;

    function automatic logic [CW-1:0] clamp_w(input logic [CW-1:0] v);
        return (v > W_C) ? W_C : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cmd_ready_out = 1'b0;
        w_ready_out   = 1'b0;
        x_ready_out   = 1'b0;
        w_take        = 1'b0;
        w_beat        = 1'b0;
        cnt_inc       = 1'b0;
        done_nxt      = 1'b0;
        s0_vld        = 1'b0;
        s0_sw         = 1'b0;
        s0_data       = '0;
        case (state)
            IDLE: begin
                cmd_ready_out = !rst;
                if (cmd_valid_in) state_nxt = LOAD_W;
            end
            LOAD_W: begin
                // rows at or beyond k are zero rows generated without a handshake
                w_take      = (CW'(cnt) < k_q);
                w_ready_out = w_take && !rst;
                w_beat      = !w_take || w_valid_in;
                cnt_inc     = w_beat;
                if (w_beat && cnt == LAST) state_nxt = SETTLE;
            end
            SETTLE: begin
                cnt_inc = 1'b1;
                if (cnt == LAST) state_nxt = SWITCH;
            end
            SWITCH: begin
                s0_sw     = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                x_ready_out = !rst;
                s0_vld      = x_valid_in;
                s0_data     = x_data_in;
                if (x_valid_in && x_last_in) state_nxt = DRAIN;
            end
            DRAIN: begin
                cnt_inc = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_fire = cmd_valid_in && cmd_ready_out;

    always_ff @(posedge clk) begin
        if (rst || state_nxt != state) cnt <= '0;
        else if (cnt_inc)              cnt <= cnt + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q                      <= '0;
            cols_q                   <= '0;
            ub_rd_col_size_out       <= '0;
            ub_rd_col_size_valid_out <= 1'b0;
            done_out                 <= 1'b0;
        end else begin
            ub_rd_col_size_valid_out <= cmd_fire;
            done_out                 <= done_nxt;
            if (cmd_fire) begin
                k_q                <= clamp_w(cmd_k_in);
                cols_q             <= clamp_w(cmd_cols_in);
                ub_rd_col_size_out <= clamp_w(cmd_cols_in);
            end
        end
    end

    // north edge: one weight row per beat, all columns in the same cycle
    for (genvar j = 0; j < W; j++) begin : g_col
        localparam logic [CW-1:0] J_C = CW'(j);
        always_ff @(posedge clk) begin
            if (rst || !w_beat) begin
                sys_accept_w_out[j] <= 1'b0;
                sys_index_out[j]    <= '0;
                sys_weight_out[j]   <= '0;
            end else begin
                sys_accept_w_out[j] <= 1'b1;
                sys_index_out[j]    <= cnt;
                sys_weight_out[j]   <= (w_take && J_C < cols_q) ? w_data_in[j] : '0;
            end
        end
    end

    // west edge: row i is delayed through i+1 registers
    for (genvar i = 0; i < W; i++) begin : g_row
        logic [i:0][DW-1:0] data_p;
        logic [i:0]         vld_p;
        logic [i:0]         sw_p;
        if (i == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_p <= '0;
                    vld_p  <= '0;
                    sw_p   <= '0;
                end else begin
                    data_p <= s0_data[i];
                    vld_p  <= s0_vld;
                    sw_p   <= s0_sw;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_p <= '0;
                    vld_p  <= '0;
                    sw_p   <= '0;
                end else begin
                    data_p <= {data_p[i-1:0], s0_data[i]};
                    vld_p  <= {vld_p[i-1:0], s0_vld};
                    sw_p   <= {sw_p[i-1:0], s0_sw};
                end
            end
        end
        assign sys_data_out[i]   = data_p[i];
        assign sys_valid_out[i]  = vld_p[i];
        assign sys_switch_out[i] = sw_p[i];
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Drive-side sequencer for the `systolic` array: accepts a command, loads one weight tile into the array's shadow buffers column-parallel with row indices, issues the per-row switch token, then streams input vectors with a diagonal row skew so every array row sees switch one cycle before its first valid. It sits between the unified buffer read ports and the array's north and west edges. It also programs the array's active-column mask.

## Interface
- SYSTOLIC_ARRAY_WIDTH, 16, array dimension W (rows = columns)
- DATA_WIDTH_IN, 8, signed element width

- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cmd_valid_in / cmd_ready_out  in/out  1  command handshake
- cmd_k_in  in  clog2(W+1)  weight rows to consume; 0 or >W means none or W respectively
- cmd_cols_in  in  clog2(W+1)  active columns; >W clamps to W
- w_data_in  in  W x DATA_WIDTH_IN  one weight row, element j is for column j
- w_valid_in / w_ready_out  in/out  1  weight row handshake
- x_data_in  in  W x DATA_WIDTH_IN  one input vector, element i is for array row i
- x_valid_in / x_ready_out  in/out  1  vector handshake
- x_last_in  in  1  marks final vector of the command
- sys_weight_out, sys_index_out, sys_accept_w_out  out  W x {DATA_WIDTH_IN, clog2(W), 1}  north edge, per column
- sys_data_out, sys_valid_out, sys_switch_out  out  W x {DATA_WIDTH_IN, 1, 1}  west edge, per row
- ub_rd_col_size_out  out  clog2(W+1)  column count for the array mask
- ub_rd_col_size_valid_out  out  1  one-cycle strobe with column count
- done_out  out  1  one-cycle pulse when the last vector has fully left the feeder

## Operation
- States: IDLE, LOAD_W, SETTLE, SWITCH, STREAM, DRAIN.
- IDLE: cmd_ready_out = 1 (forced 0 while rst). On cmd accept: latch k, cols; next cycle ub_rd_col_size_out = cols, strobe high one cycle; row counter r = 0; go LOAD_W.
- LOAD_W: per beat r in 0..W-1. If r < k: w_ready_out = 1, beat advances only on w_valid_in. If r >= k: no input consumed; zero row generated internally, advances every cycle. Beat drives, one cycle later, on every column j: weight = (j < cols) ? element j : 0, index = r, accept_w = 1. Cycles without a beat drive accept_w = 0, weight = 0, index = 0. After beat W-1, go SETTLE.
- SETTLE: counts W cycles (weight propagation to row W-1), then SWITCH.
- SWITCH: one cycle; injects a switch token (valid 0) into skew stage 0; go STREAM.
- STREAM: x_ready_out = 1 (no back-pressure from the array). Each cycle stage 0 takes valid = x_valid_in, data = x_data_in; idle cycles inject bubbles. On accept with x_last_in, go DRAIN.
- DRAIN: counts W cycles, then pulses done_out and returns to IDLE.
- Skew: row i passes through i+1 registers; data, valid, switch travel together. Rows get no value change, no saturation.

## Timing
- Reset: all outputs 0 (sys_* vectors, index, strobes, done_out, ready outputs); skew registers cleared; state IDLE. Reset in any state aborts: no done_out, no partial skew contents survive.
- Command accepted at cycle C: col strobe at C+1; first weight beat visible at C+2 at the earliest.
- Weight beat accepted at cycle t appears on north outputs at t+1, all columns same cycle (no column skew).
- Last weight beat visible at L: SWITCH occupies cycle L+W; sys_switch_out[i] high exactly at L+W+1+i for one cycle.
- Vector accepted at cycle T: sys_data_out[i]/sys_valid_out[i] at T+1+i. First vector can be accepted at L+W+1, giving valid on row i at L+W+2+i, one cycle after switch.
- Last vector accepted at T: row W-1 valid at T+W; done_out at T+W+1; cmd_ready_out = 1 from T+W+1.
- x_ready_out and w_ready_out are 0 outside STREAM and LOAD_W (r<k) respectively; x_valid_in outside STREAM is ignored.
- k = 0: LOAD_W takes exactly W cycles, w_ready_out never high.

## Test plan
- W=4, cmd k=4 cols=4, weight rows {1,2,3,4}x4 back-to-back -> north outputs index 0..3 on consecutive cycles with accept_w=1, col strobe value 4 one cycle after accept.
- Same, w_valid_in gapped every other cycle -> beats stretch, accept_w=0 in gaps, index order intact.
- k=2 cols=3 -> only 2 rows consumed; rows 2,3 driven with zero weights; column 3 weight always 0.
- Stream 3 vectors x=[10,20,30,40]... with a one-cycle gap -> row i switch at L+W+1+i, valid/data on row i at T+1+i, bubble preserved in every row.
- Last vector at T -> done_out high only at T+W+1; new command accepted at T+W+1.
- Assert rst mid-STREAM -> next cycle all outputs 0, no done_out, IDLE with cmd_ready_out=1 after release.
